// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU arbiter
package alu_arb_pkg;

  // Controller phases: waiting for a request, driving the ALU, returning the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OPC_W = 3;
  localparam int W_DEF = 16;

  // Index width for a vector of n requesters (never below one bit)
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rtl/alu_arbiter_rr_pick.sv - combinational round-robin selector
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);

  // Scan from the requester after the last winner, wrapping once; first hit wins
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!any_req && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        any_req  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one external ALU among N requesters
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*W-1:0]     req_a,
  input  logic [N*W-1:0]     req_b,
  input  logic [N-1:0]       req_cin,
  input  logic [N*OPC_W-1:0] req_opc,
  output logic [N-1:0]       rsp_valid,
  input  logic [N-1:0]       rsp_ready,
  output logic [W-1:0]       rsp_w,
  output logic               rsp_zero,
  output logic               rsp_neg,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic               alu_cin,
  output logic [OPC_W-1:0]   alu_opc,
  input  logic [W-1:0]       alu_w,
  input  logic               alu_zero,
  input  logic               alu_neg,
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam int IW = idx_w(N);

  state_t             state;
  state_t             state_nxt;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      owner;
  logic [N-1:0]       pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               any_req;
  logic               accept;
  logic               capture;
  logic               complete;

  logic [W-1:0]       sel_a;
  logic [W-1:0]       sel_b;
  logic               sel_cin;
  logic [OPC_W-1:0]   sel_opc;

  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic               op_cin;
  logic [OPC_W-1:0]   op_opc;

  logic [W-1:0]       res_w;
  logic               res_zero;
  logic               res_neg;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req     (req_valid),
    .last    (last_grant),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any_req (any_req)
  );

  // Route the winning requester's operands toward the operand registers
  always_comb begin
    sel_a   = req_a[pick_idx*W +: W];
    sel_b   = req_b[pick_idx*W +: W];
    sel_cin = req_cin[pick_idx];
    sel_opc = req_opc[pick_idx*OPC_W +: OPC_W];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs; req_ready is held off while reset is asserted
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst_n) begin
          req_ready = pick_gnt;
        end
        if (any_req) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand registers and owner, loaded only on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      op_opc <= '0;
      owner  <= '0;
    end else if (accept) begin
      op_a   <= sel_a;
      op_b   <= sel_b;
      op_cin <= sel_cin;
      op_opc <= sel_opc;
      owner  <= pick_idx;
    end
  end

  // Result registers, loaded at the end of the single ALU cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_w    <= '0;
      res_zero <= 1'b0;
      res_neg  <= 1'b0;
    end else if (capture) begin
      res_w    <= alu_w;
      res_zero <= alu_zero;
      res_neg  <= alu_neg;
    end
  end

  // Fairness pointer and completion counter advance only when the owner takes its result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(N - 1);
      op_count   <= '0;
    end else if (complete) begin
      last_grant <= owner;
      op_count   <= op_count + 16'd1;
    end
  end

  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_cin  = op_cin;
  assign alu_opc  = op_opc;
  assign rsp_w    = res_w;
  assign rsp_zero = res_zero;
  assign rsp_neg  = res_neg;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_cin;
  logic [N*3-1:0]   req_opc;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [W-1:0]     rsp_w;
  logic             rsp_zero;
  logic             rsp_neg;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic             alu_cin;
  logic [2:0]       alu_opc;
  logic [W-1:0]     alu_w;
  logic             alu_zero;
  logic             alu_neg;
  logic             busy;
  logic [15:0]      op_count;
  logic [17:0]      alu_res;

  int total = 0;
  int bad   = 0;
  int m_last;
  logic [15:0] m_count;

  alu_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_opc   (req_opc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_w     (rsp_w),
    .rsp_zero  (rsp_zero),
    .rsp_neg   (rsp_neg),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_opc   (alu_opc),
    .alu_w     (alu_w),
    .alu_zero  (alu_zero),
    .alu_neg   (alu_neg),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Bench ALU: {zero, neg, w}
  function automatic logic [17:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic [2:0] opc);
    logic [15:0] w;
    case (opc)
      3'd0:    w = a + b + {15'd0, cin};
      3'd1:    w = a - b;
      3'd2:    w = a & b;
      3'd3:    w = a | b;
      3'd4:    w = a ^ b;
      3'd5:    w = ~a;
      3'd6:    w = {a[14:0], cin};
      default: w = b;
    endcase
    return {(w == 16'd0), w[15], w};
  endfunction

  always_comb alu_res = alu_fn(alu_a, alu_b, alu_cin, alu_opc);
  assign alu_w    = alu_res[15:0];
  assign alu_neg  = alu_res[16];
  assign alu_zero = alu_res[17];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [2:0] opc);
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_cin[i]        = cin;
    req_opc[i*3 +: 3] = opc;
    req_valid[i]      = 1'b1;
  endtask

  task automatic set_req_rand(input int i);
    set_req(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_op_count"}, op_count, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_cin"}, alu_cin, 0);
    check({tag, "_alu_opc"}, alu_opc, 0);
    check({tag, "_rsp_w"}, rsp_w, 0);
    check({tag, "_rsp_flags"}, {rsp_zero, rsp_neg}, 0);
  endtask

  // Assert reset off-edge, check outputs immediately, hold two edges, release
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    tick();
    tick();
    check({tag, "_held_rsp_valid"}, rsp_valid, 0);
    check({tag, "_held_busy"}, busy, 0);
    rst_n   = 1'b1;
    m_last  = N - 1;
    m_count = 16'd0;
  endtask

  // One full operation from the current request set, checked against the model
  task automatic op_round(input int stall, input bit refresh, output int g);
    int eg;
    int idx;
    logic [15:0] ea, eb;
    logic ec;
    logic [2:0] eo;
    logic [17:0] er;
    eg = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (eg < 0 && req_valid[idx]) eg = idx;
    end
    g = eg;
    rsp_ready = (stall == 0) ? 4'hF : 4'h0;
    #1;
    if (eg < 0) begin
      check("idle_req_ready", req_ready, 0);
      tick();
      check("idle_busy", busy, 0);
      return;
    end
    check("req_ready", req_ready, 32'd1 << eg);
    ea = req_a[eg*W +: W];
    eb = req_b[eg*W +: W];
    ec = req_cin[eg];
    eo = req_opc[eg*3 +: 3];
    er = alu_fn(ea, eb, ec, eo);
    tick();
    check("exec_busy", busy, 1);
    check("exec_alu_a", alu_a, ea);
    check("exec_alu_b", alu_b, eb);
    check("exec_alu_cin_opc", {alu_cin, alu_opc}, {ec, eo});
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_req_ready", req_ready, 0);
    if (refresh) set_req_rand(eg);
    else req_valid[eg] = 1'b0;
    tick();
    check("rsp_valid", rsp_valid, 32'd1 << eg);
    check("rsp_w", rsp_w, er[15:0]);
    check("rsp_flags", {rsp_zero, rsp_neg}, {er[17], er[16]});
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 4'hF & ~(4'b1 << eg);
      tick();
      check("stall_rsp_valid", rsp_valid, 32'd1 << eg);
      check("stall_rsp_w", rsp_w, er[15:0]);
      check("stall_req_ready", req_ready, 0);
      check("stall_op_count", op_count, m_count);
    end
    rsp_ready = 4'b1 << eg;
    tick();
    m_count = m_count + 16'd1;
    m_last  = eg;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_busy", busy, 0);
    check("op_count", op_count, m_count);
  endtask

  initial begin
    int g;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_opc   = '0;
    rsp_ready = '0;
    m_last    = N - 1;
    m_count   = 16'd0;
    #2;
    do_reset("rst0");

    // Single request from requester 2: 3 + 4 + 1
    set_req(2, 16'h0003, 16'h0004, 1'b1, 3'd0);
    op_round(0, 1'b0, g);
    check("single_grant", g, 2);
    check("single_rsp_w", rsp_w, 16'h0008);
    check("single_flags", {rsp_zero, rsp_neg}, 2'b00);
    check("single_op_count", op_count, 1);

    // Fresh reset, then all four continuously valid: strict rotation
    do_reset("rst1");
    for (int i = 0; i < N; i++) set_req_rand(i);
    for (int r = 0; r < 5; r++) begin
      op_round(0, 1'b1, g);
      check("rotation_grant", g, exp_order[r]);
    end
    req_valid = '0;

    // 0x8000 + 0x8000 wraps to zero
    set_req(1, 16'h8000, 16'h8000, 1'b0, 3'd0);
    op_round(0, 1'b0, g);
    check("zero_grant", g, 1);
    check("zero_rsp_w", rsp_w, 16'h0000);
    check("zero_flags", {rsp_zero, rsp_neg}, 2'b10);

    // 0x7FFF + 1 sets the sign bit
    set_req(0, 16'h7FFF, 16'h0001, 1'b0, 3'd0);
    op_round(0, 1'b0, g);
    check("neg_grant", g, 0);
    check("neg_rsp_w", rsp_w, 16'h8000);
    check("neg_flag", rsp_neg, 1);

    // Ten-cycle response stall with other requesters waiting
    set_req_rand(1);
    set_req_rand(2);
    set_req_rand(3);
    op_round(10, 1'b0, g);
    check("stall_grant", g, 1);
    req_valid = '0;

    // Randomised traffic
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        req_valid = '0;
      end else begin
        for (int i = 0; i < N; i++)
          if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req_rand(i);
      end
      op_round($urandom_range(0, 2), 1'($urandom_range(0, 1)), g);
    end
    req_valid = '0;

    // Reset while an operation is in EXEC
    set_req_rand(1);
    rsp_ready = 4'hF;
    #1;
    tick();
    check("pre_reset_busy", busy, 1);
    req_valid = 4'b1001;
    do_reset("rst_exec");
    set_req(0, 16'h1234, 16'h0001, 1'b0, 3'd0);
    set_req(3, 16'h4321, 16'h0001, 1'b0, 3'd0);
    op_round(0, 1'b0, g);
    check("post_reset_grant", g, 0);
    check("post_reset_rsp_w", rsp_w, 16'h1235);
    req_valid = '0;

    // Counter wrap from 0xFFFF
    tick();
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    m_count = 16'hFFFF;
    check("preload_op_count", op_count, 16'hFFFF);
    set_req_rand(2);
    op_round(0, 1'b0, g);
    check("wrap_op_count", op_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
